// File: rtl/time_disp_pkg.sv
// Shared constants and helpers for the time-setting clock: FSM encoding,
// field limits, blink mask bit positions and the debounce length calculation.
package time_disp_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_SET_HOUR = 2'd1;
    localparam logic [1:0] ST_SET_MIN  = 2'd2;
    localparam logic [1:0] ST_SET_SEC  = 2'd3;

    localparam logic [5:0] HOUR_MAX = 6'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    localparam int BLINK_IDX_HOUR = 2;
    localparam int BLINK_IDX_MIN  = 1;
    localparam int BLINK_IDX_SEC  = 0;

    // Small clock frequencies (simulation builds) round to zero ms-cycles; never go below one.
    function automatic int debounce_cycles(input int clk_freq, input int ms);
        int c;
        c = (clk_freq / 1000) * ms;
        return (c < 1) ? 1 : c;
    endfunction

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max_v);
        return (v >= max_v) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [1:0] next_mode_state(input logic [1:0] s);
        case (s)
            ST_RUN:      return ST_SET_HOUR;
            ST_SET_HOUR: return ST_SET_MIN;
            ST_SET_MIN:  return ST_SET_SEC;
            default:     return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus press debouncer for one active-low key.
// Emits a single-cycle press pulse after DEBOUNCE_CNT consecutive low samples.
module key_debounce #(
    parameter int DEBOUNCE_CNT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [1:0]       vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // The synchronizer resets to "released"; vld_q keeps that fake high sample from
    // arming the counter, so a key held through reset needs a real release first.
    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
        vld_d   = {vld_q[0], 1'b1};
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (!vld_q[1]) begin
            cnt_d = '0;
        end else if (sync2_q) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d   = cnt_q - CNT_ONE;
            press_d = (cnt_q == CNT_ONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            vld_q   <= 2'b00;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/time_cnt_set.sv
// Real-time clock with key-driven hour/minute/second setting.
// Optional field blinking while setting is enabled by defining TIME_SET_BLINK_EN.
//
// state       | meaning
// ST_RUN      | clock runs from the 1 s prescaler, inc key ignored
// ST_SET_HOUR | prescaler held, inc advances hour
// ST_SET_MIN  | prescaler held, inc advances minute
// ST_SET_SEC  | prescaler held, inc advances second
module time_cnt_set
    import time_disp_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DEBOUNCE_MS  = 20,
    parameter int DEBOUNCE_CNT = debounce_cycles(CLK_FREQ, DEBOUNCE_MS)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [2:0] blink
);

    localparam int PRESC_W = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

    logic mode_pulse;
    logic inc_pulse;

    key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb_mode (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key_mode),
        .press   (mode_pulse)
    );

    key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb_inc (
        .clk     (clk),
        .rst     (rst),
        .key_raw (key_inc),
        .press   (inc_pulse)
    );

    logic [1:0]         state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [5:0]         hour_q, hour_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         sec_q, sec_d;
    logic               tick;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tick    = 1'b0;
        if (state_q == ST_RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_ONE;
            end
            if (tick) begin
                sec_d = wrap_inc(sec_q, SEC_MAX);
                if (sec_q == SEC_MAX) begin
                    min_d = wrap_inc(min_q, MIN_MAX);
                    if (min_q == MIN_MAX) begin
                        hour_d = wrap_inc(hour_q, HOUR_MAX);
                    end
                end
            end
            if (mode_pulse) begin
                state_d = ST_SET_HOUR;
                presc_d = '0;
            end
        end else begin
            // Prescaler parked at zero so the first tick after setting is a full second away.
            presc_d = '0;
            if (mode_pulse) begin
                state_d = next_mode_state(state_q);
            end else if (inc_pulse) begin
                case (state_q)
                    ST_SET_HOUR: hour_d = wrap_inc(hour_q, HOUR_MAX);
                    ST_SET_MIN:  min_d  = wrap_inc(min_q, MIN_MAX);
                    default:     sec_d  = wrap_inc(sec_q, SEC_MAX);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            presc_q <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
        end
    end

    assign hour   = hour_q;
    assign minute = min_q;
    assign second = sec_q;

`ifdef TIME_SET_BLINK_EN
    localparam int BLINK_HALF = (CLK_FREQ / 4 > 0) ? CLK_FREQ / 4 : 1;
    localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_HALF - 1);
    localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);

    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               restart;

    // Any edit or field change restarts in the visible phase so the user sees the new value.
    assign restart = (state_d != state_q) ||
                     ((state_q != ST_RUN) && inc_pulse && !mode_pulse);

    always_comb begin
        blink_cnt_d = blink_cnt_q - BLINK_ONE;
        phase_d     = phase_q;
        if (restart || (state_q == ST_RUN)) begin
            blink_cnt_d = BLINK_LOAD;
            phase_d     = 1'b0;
        end else if (blink_cnt_q == '0) begin
            blink_cnt_d = BLINK_LOAD;
            phase_d     = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= BLINK_LOAD;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        blink                 = 3'b000;
        blink[BLINK_IDX_HOUR] = phase_q && (state_q == ST_SET_HOUR);
        blink[BLINK_IDX_MIN]  = phase_q && (state_q == ST_SET_MIN);
        blink[BLINK_IDX_SEC]  = phase_q && (state_q == ST_SET_SEC);
    end
`else
    assign blink = 3'b000;
`endif

endmodule
